// File: rtl/cpu_pkg.sv
// Shared control codes and ALU opcodes for the datapath and its controller.
package cpu_pkg;

    localparam int unsigned CODE_W = 4;

    localparam logic [CODE_W-1:0] CTL_CLEAR  = 4'd0;
    localparam logic [CODE_W-1:0] CTL_LOAD   = 4'd1;
    localparam logic [CODE_W-1:0] CTL_HOLD   = 4'd2;
    localparam logic [CODE_W-1:0] CTL_SHIFTR = 4'd3;

    localparam logic [CODE_W-1:0] ALU_ADD   = 4'd0;
    localparam logic [CODE_W-1:0] ALU_SUB   = 4'd1;
    localparam logic [CODE_W-1:0] ALU_AND   = 4'd2;
    localparam logic [CODE_W-1:0] ALU_OR    = 4'd3;
    localparam logic [CODE_W-1:0] ALU_XOR   = 4'd4;
    localparam logic [CODE_W-1:0] ALU_NOTA  = 4'd5;
    localparam logic [CODE_W-1:0] ALU_PASSA = 4'd6;
    localparam logic [CODE_W-1:0] ALU_PASSB = 4'd7;

endpackage

// File: rtl/reg_ctl.sv
// WIDTH-bit register driven by a 4-bit control code: CLEAR, LOAD, HOLD, SHIFTR.
module reg_ctl
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CODE_W-1:0]  code,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   q
);

    // Undefined codes fall through to hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            case (code)
                CTL_CLEAR:  q <= '0;
                CTL_LOAD:   q <= load_val;
                CTL_SHIFTR: q <= {1'b0, q[WIDTH-1:1]};
                default:    q <= q;
            endcase
        end
    end

endmodule

// File: rtl/datapath_xyz.sv
// Three-register datapath: X from data_in, Y from the ALU, Z from Y,
// with registered carry/zero flags and a Z-load strobe.
module datapath_xyz
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CODE_W-1:0]  tx,
    input  logic [CODE_W-1:0]  ty,
    input  logic [CODE_W-1:0]  tz,
    input  logic [CODE_W-1:0]  tula,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [WIDTH-1:0]   z_out,
    output logic               carry,
    output logic               zero,
    output logic               z_valid
);

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [WIDTH:0]   sum_ext;

    reg_ctl #(.WIDTH(WIDTH)) u_reg_x (
        .clock    (clock),
        .reset    (reset),
        .code     (tx),
        .load_val (data_in),
        .q        (x_out)
    );

    reg_ctl #(.WIDTH(WIDTH)) u_reg_y (
        .clock    (clock),
        .reset    (reset),
        .code     (ty),
        .load_val (alu_result),
        .q        (y_out)
    );

    reg_ctl #(.WIDTH(WIDTH)) u_reg_z (
        .clock    (clock),
        .reset    (reset),
        .code     (tz),
        .load_val (y_out),
        .q        (z_out)
    );

    assign sum_ext = (WIDTH+1)'(x_out) + (WIDTH+1)'(y_out);

    // ALU operates on the registered X/Y, so every register sees pre-edge values.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (tula)
            ALU_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
            end
            ALU_SUB: begin
                alu_result = x_out - y_out;
                alu_carry  = (x_out < y_out);
            end
            ALU_AND:   alu_result = x_out & y_out;
            ALU_OR:    alu_result = x_out | y_out;
            ALU_XOR:   alu_result = x_out ^ y_out;
            ALU_NOTA:  alu_result = ~x_out;
            ALU_PASSA: alu_result = x_out;
            ALU_PASSB: alu_result = y_out;
            default:   alu_result = '0;
        endcase
    end

    // Flags track the ALU only on cycles that write Y.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry   <= 1'b0;
            zero    <= 1'b0;
            z_valid <= 1'b0;
        end else begin
            z_valid <= (tz == CTL_LOAD);
            if (ty == CTL_LOAD) begin
                carry <= alu_carry;
                zero  <= (alu_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_datapath_xyz.sv
// Scoreboard bench for datapath_xyz: directed steps queue expected state,
// a monitor compares after each rising edge.
module tb_datapath_xyz;

    logic       clock;
    logic       reset;
    logic [3:0] tx, ty, tz, tula;
    logic [7:0] data_in;
    logic [7:0] x_out, y_out, z_out;
    logic       carry, zero, z_valid;

    typedef struct {
        int         id;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic       c;
        logic       zr;
        logic       zv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    datapath_xyz #(.WIDTH(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .tx      (tx),
        .ty      (ty),
        .tz      (tz),
        .tula    (tula),
        .data_in (data_in),
        .x_out   (x_out),
        .y_out   (y_out),
        .z_out   (z_out),
        .carry   (carry),
        .zero    (zero),
        .z_valid (z_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input int id, input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", id, name, act, want);
        end
    endtask

    // Monitor: every rising edge the oldest pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.id, "x_out",   x_out,           e.x);
                cmp(e.id, "y_out",   y_out,           e.y);
                cmp(e.id, "z_out",   z_out,           e.z);
                cmp(e.id, "carry",   8'(carry),       8'(e.c));
                cmp(e.id, "zero",    8'(zero),        8'(e.zr));
                cmp(e.id, "z_valid", 8'(z_valid),     8'(e.zv));
            end
        end
    end

    int step_id = 0;

    task automatic step(input logic rst, input logic [3:0] ctx, input logic [3:0] cty,
                        input logic [3:0] ctz, input logic [3:0] op, input logic [7:0] din,
                        input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] ez,
                        input logic ec, input logic ezr, input logic ezv);
        exp_t e;
        @(negedge clock);
        reset   = rst;
        tx      = ctx;
        ty      = cty;
        tz      = ctz;
        tula    = op;
        data_in = din;
        step_id++;
        e.id = step_id; e.x = ex; e.y = ey; e.z = ez; e.c = ec; e.zr = ezr; e.zv = ezv;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; tx = 4'd2; ty = 4'd2; tz = 4'd2; tula = 4'd0; data_in = 8'h00;

        //    rst tx ty tz tula din     X      Y      Z      c  zr zv
        step(1, 2, 2, 2, 0, 8'h00,   8'h00, 8'h00, 8'h00, 0, 0, 0);
        // build arbitrary state, then reset over active LOADs
        step(0, 1, 1, 1, 6, 8'hAA,   8'hAA, 8'h00, 8'h00, 0, 1, 1);
        step(0, 2, 1, 2, 6, 8'h00,   8'hAA, 8'hAA, 8'h00, 0, 0, 0);
        step(1, 1, 1, 1, 0, 8'h55,   8'h00, 8'h00, 8'h00, 0, 0, 0);
        // controller sequence with ADD
        step(0, 1, 0, 2, 0, 8'h05,   8'h05, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 1, 2, 0, 8'h03,   8'h03, 8'h05, 8'h00, 0, 0, 0);
        step(0, 0, 1, 2, 0, 8'h00,   8'h00, 8'h08, 8'h00, 0, 0, 0);
        step(0, 2, 3, 2, 0, 8'h00,   8'h00, 8'h04, 8'h00, 0, 0, 0);
        step(0, 2, 2, 1, 0, 8'h00,   8'h00, 8'h04, 8'h04, 0, 0, 1);
        step(0, 2, 2, 2, 0, 8'h00,   8'h00, 8'h04, 8'h04, 0, 0, 0);
        // ADD overflow: 0xFF + 0x01
        step(0, 1, 0, 2, 0, 8'h01,   8'h01, 8'h00, 8'h04, 0, 0, 0);
        step(0, 1, 1, 2, 6, 8'hFF,   8'hFF, 8'h01, 8'h04, 0, 0, 0);
        step(0, 2, 1, 2, 0, 8'h00,   8'hFF, 8'h00, 8'h04, 1, 1, 0);
        // SUB with borrow: 3 - 5
        step(0, 1, 0, 2, 0, 8'h05,   8'h05, 8'h00, 8'h04, 1, 1, 0);
        step(0, 1, 1, 2, 6, 8'h03,   8'h03, 8'h05, 8'h04, 0, 0, 0);
        step(0, 2, 1, 2, 1, 8'h00,   8'h03, 8'hFE, 8'h04, 1, 0, 0);
        // load X=12 Y=34 Z=56, then illegal codes hold
        step(0, 1, 0, 2, 0, 8'h56,   8'h56, 8'h00, 8'h04, 1, 0, 0);
        step(0, 1, 1, 2, 6, 8'h34,   8'h34, 8'h56, 8'h04, 0, 0, 0);
        step(0, 1, 1, 1, 6, 8'h12,   8'h12, 8'h34, 8'h56, 0, 0, 1);
        step(0, 4, 5, 15, 0, 8'hFF,  8'h12, 8'h34, 8'h56, 0, 0, 0);
        step(0, 9, 12, 7, 1, 8'hEE,  8'h12, 8'h34, 8'h56, 0, 0, 0);
        step(0, 2, 1, 2, 9, 8'h00,   8'h12, 8'h00, 8'h56, 0, 1, 0);
        // remaining logic ops and shifts
        step(0, 2, 1, 2, 5, 8'h00,   8'h12, 8'hED, 8'h56, 0, 0, 0);
        step(0, 2, 3, 2, 0, 8'h00,   8'h12, 8'h76, 8'h56, 0, 0, 0);
        step(0, 2, 1, 2, 4, 8'h00,   8'h12, 8'h64, 8'h56, 0, 0, 0);
        step(0, 2, 1, 2, 2, 8'h00,   8'h12, 8'h00, 8'h56, 0, 1, 0);
        step(0, 2, 1, 2, 3, 8'h00,   8'h12, 8'h12, 8'h56, 0, 0, 0);
        step(0, 3, 2, 2, 0, 8'h00,   8'h09, 8'h12, 8'h56, 0, 0, 0);
        step(0, 2, 2, 0, 0, 8'h00,   8'h09, 8'h12, 8'h00, 0, 0, 0);
        // simultaneous Y and Z load, back-to-back z_valid
        step(0, 1, 2, 2, 0, 8'h10,   8'h10, 8'h12, 8'h00, 0, 0, 0);
        step(0, 1, 1, 2, 6, 8'h01,   8'h01, 8'h10, 8'h00, 0, 0, 0);
        step(0, 2, 1, 1, 0, 8'h00,   8'h01, 8'h11, 8'h10, 0, 0, 1);
        step(0, 2, 2, 1, 0, 8'h00,   8'h01, 8'h11, 8'h11, 0, 0, 1);
        // reset mid-op, then immediate normal operation
        step(1, 1, 1, 1, 0, 8'hAB,   8'h00, 8'h00, 8'h00, 0, 0, 0);
        step(0, 1, 2, 2, 0, 8'h07,   8'h07, 8'h00, 8'h00, 0, 0, 0);
        // carry set, then cleared by an undefined opcode
        step(0, 1, 2, 2, 0, 8'hFF,   8'hFF, 8'h00, 8'h00, 0, 0, 0);
        step(0, 2, 1, 2, 6, 8'h00,   8'hFF, 8'hFF, 8'h00, 0, 0, 0);
        step(0, 2, 1, 2, 0, 8'h00,   8'hFF, 8'hFE, 8'h00, 1, 0, 0);
        step(0, 2, 1, 2, 8, 8'h00,   8'hFF, 8'h00, 8'h00, 0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
